uart_tx_ctrl: RTL and testbench

Transmit sequencer for the UART transmit path. It accepts a byte through a valid/ready handshake and serializes it LSB-first. Each bit is held for a programmable number of clocks. It drives the select lines, data bit and parity bit of the downstream `tx_mux`, so `tx_packet` carries start, data, optional parity and stop bits in order. One controller owns one `tx_mux` instance.

---
 rtl/uart_tx_ctrl_pkg.sv | 28 ++
 rtl/uart_baud_cnt.sv | 38 +++
 rtl/uart_tx_ctrl.sv | 122 ++++++++++++
 tb/tb_uart_tx_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART transmit path: tx_mux select codes,
// sequencer state encoding and the state-to-select mapping.
package uart_tx_ctrl_pkg;

   localparam logic [1:0] SEL_START  = 2'b00;
   localparam logic [1:0] SEL_DATA   = 2'b01;
   localparam logic [1:0] SEL_PARITY = 2'b10;
   localparam logic [1:0] SEL_STOP   = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   // IDLE and STOP share the mark level, so both map to the stop select.
   function automatic logic [1:0] sel_of(input tx_state_e st);
      case (st)
         ST_START:  return SEL_START;
         ST_DATA:   return SEL_DATA;
         ST_PARITY: return SEL_PARITY;
         default:   return SEL_STOP;
      endcase
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// terminal count; wraps to zero on the tick so each bit restarts cleanly.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = en && (cnt_q == TERM);

   always_comb begin
      cnt_d = cnt_q;
      if (clr || tick) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte on a valid/ready handshake and
// drives the tx_mux selects, data bit and parity bit for start/data/parity/stop.
module uart_tx_ctrl
   import uart_tx_ctrl_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter bit PARITY_EN    = 1'b1,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       data_bit,
   output logic       parity_bit,
   output logic       s0,
   output logic       s1
);

   tx_state_e  state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic       parity_q, parity_d;
   logic       data_bit_q, data_bit_d;
   logic [1:0] sel_q, sel_d;
   logic       tx_ready_q, tx_ready_d;
   logic       tx_done_q, tx_done_d;

   logic baud_tick;

   // Counter sits at zero throughout IDLE, so every state entry starts a full bit time.
   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk (clk),
      .rst (rst),
      .clr (state_q == ST_IDLE),
      .en  (state_q != ST_IDLE),
      .tick(baud_tick)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      parity_d   = parity_q;
      data_bit_d = data_bit_q;
      tx_done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (tx_valid && tx_ready_q) begin
               state_d   = ST_START;
               shift_d   = tx_data;
               bit_idx_d = 3'd0;
               parity_d  = (^tx_data) ^ PARITY_ODD;
            end
         end
         ST_START: begin
            if (baud_tick) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (baud_tick) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = 3'd0;
                  state_d   = PARITY_EN ? ST_PARITY : ST_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (baud_tick) state_d = ST_STOP;
         end
         ST_STOP: begin
            if (baud_tick) begin
               state_d   = ST_IDLE;
               tx_done_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they register in step with it.
      sel_d      = sel_of(state_d);
      tx_ready_d = (state_d == ST_IDLE);
      if (state_d == ST_DATA) data_bit_d = shift_d[0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         shift_q    <= 8'h00;
         bit_idx_q  <= 3'd0;
         parity_q   <= 1'b0;
         data_bit_q <= 1'b1;
         sel_q      <= SEL_STOP;
         tx_ready_q <= 1'b1;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         parity_q   <= parity_d;
         data_bit_q <= data_bit_d;
         sel_q      <= sel_d;
         tx_ready_q <= tx_ready_d;
         tx_done_q  <= tx_done_d;
      end
   end

   assign tx_ready   = tx_ready_q;
   assign tx_done    = tx_done_q;
   assign data_bit   = data_bit_q;
   assign parity_bit = parity_q;
   assign s0         = sel_q[0];
   assign s1         = sel_q[1];

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: three configurations (even parity, odd parity, no parity)
// run side by side; a scoreboard of expected serial frames is checked by a line monitor.
module tb_uart_tx_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input bit ok, input string what, input int cfg,
                        input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s cfg=%0d actual=%0h required=%0h", what, cfg, got, exp);
      end
   endtask

   for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
      localparam int         CPB   = (gi == 2) ? 3 : 4;
      localparam bit         PEN   = (gi != 2);
      localparam bit         PODD  = (gi == 1);
      localparam int         NB    = PEN ? 11 : 10;
      localparam logic [7:0] FIRST = (gi == 0) ? 8'hA5 : (gi == 1) ? 8'h01 : 8'hFF;

      logic       rst = 1'b1;
      logic       tx_valid = 1'b0;
      logic [7:0] tx_data = 8'h00;
      logic       tx_ready, tx_done, data_bit, parity_bit, s0, s1;
      bit         fin = 1'b0;

      uart_tx_ctrl #(
         .CLKS_PER_BIT(CPB),
         .PARITY_EN   (PEN),
         .PARITY_ODD  (PODD)
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .tx_valid  (tx_valid),
         .tx_data   (tx_data),
         .tx_ready  (tx_ready),
         .tx_done   (tx_done),
         .data_bit  (data_bit),
         .parity_bit(parity_bit),
         .s0        (s0),
         .s1        (s1)
      );

      // Expected line levels, one per bit time: start, 8 data LSB first, [parity], stop.
      function automatic logic [10:0] model(input logic [7:0] b);
         int          ones;
         logic [10:0] f;
         ones = 0;
         f    = '0;
         for (int i = 0; i < 8; i++) begin
            ones += int'(b[i]);
            f[i+1] = b[i];
         end
         if (PEN) begin
            f[9]  = ((ones % 2) == 1) ^ PODD;
            f[10] = 1'b1;
         end else begin
            f[9] = 1'b1;
         end
         return f;
      endfunction

      logic [10:0] sb[$];
      bit          in_frame = 0, expect_done = 0, gap_chk = 0, err = 0;
      int          cyc = 0, idle_cnt = 0, spurious = 0, par_cycles = 0, frames_done = 0;
      logic [10:0] exp_f = '0, got_f = '0;

      always @(posedge clk) begin
         logic [1:0] sel, exp_sel;
         logic       ln;
         int         p;
         #1;
         if (rst) begin
            in_frame    = 0;
            expect_done = 0;
         end else begin
            sel = {s1, s0};
            ln  = (sel == 2'b00) ? 1'b0 : (sel == 2'b01) ? data_bit :
                  (sel == 2'b10) ? parity_bit : 1'b1;
            if (sel == 2'b10) par_cycles++;
            if (expect_done) begin
               check(tx_done && tx_ready, "done_pulse", gi, {tx_done, tx_ready}, 2'b11);
               expect_done = 0;
            end else if (tx_done) begin
               spurious++;
            end
            if (!in_frame) begin
               if (sel == 2'b00) begin
                  if (gap_chk) begin
                     check(idle_cnt == 1, "b2b_gap", gi, idle_cnt, 1);
                     gap_chk = 0;
                  end
                  check(sb.size() != 0, "start_expected", gi, sb.size(), 1);
                  exp_f    = (sb.size() != 0) ? sb.pop_front() : '1;
                  in_frame = 1;
                  cyc      = 0;
                  err      = 0;
                  got_f    = '0;
               end else begin
                  idle_cnt++;
               end
            end
            if (in_frame) begin
               p = cyc / CPB;
               exp_sel = (p == 0) ? 2'b00 : (p <= 8) ? 2'b01 :
                         (PEN && p == 9) ? 2'b10 : 2'b11;
               if (sel != exp_sel || ln != exp_f[p] || tx_ready || tx_done) err = 1;
               if ((cyc % CPB) == (CPB / 2)) got_f[p] = ln;
               cyc++;
               if (cyc == NB * CPB) begin
                  in_frame    = 0;
                  idle_cnt    = 0;
                  expect_done = 1;
                  frames_done++;
                  $display("cfg=%0d frame data=%02h expected=%b got=%b timing_err=%0d",
                           gi, exp_f[8:1], exp_f, got_f, err);
                  check(got_f == exp_f && !err, "frame", gi, {20'h0, err, got_f}, {21'h0, exp_f});
               end
            end
         end
      end

      task automatic send(input logic [7:0] b, input bit hold);
         bit acc;
         acc = 0;
         @(negedge clk);
         tx_valid = 1'b1;
         tx_data  = b;
         for (int n = 0; n < 200 && !acc; n++) begin
            if (tx_ready) begin
               @(posedge clk);
               sb.push_back(model(b));
               acc = 1;
            end else begin
               @(negedge clk);
            end
         end
         check(acc, "accept", gi, {31'h0, acc}, 1);
         if (!hold) begin
            @(negedge clk);
            tx_valid = 1'b0;
         end
      endtask

      task automatic check_reset_vals();
         check({s1, s0, data_bit, parity_bit, tx_ready, tx_done} == 6'b111010, "reset_vals", gi,
               {26'h0, s1, s0, data_bit, parity_bit, tx_ready, tx_done}, 32'h3A);
      endtask

      initial begin
         logic [7:0] b;
         repeat (3) @(negedge clk);
         #1 check_reset_vals();
         @(negedge clk);
         rst = 1'b0;

         send(FIRST, 1'b0);
         repeat (NB * CPB) @(negedge clk);

         // Back-to-back with valid held: one idle clock between frames.
         send(8'h55, 1'b1);
         @(negedge clk);
         gap_chk = 1;
         send(8'hAA, 1'b0);

         // Offer a new byte while busy in DATA; it must be ignored.
         send(8'($urandom), 1'b0);
         repeat (2 * CPB) @(negedge clk);
         tx_data  = 8'h00;
         tx_valid = 1'b1;
         #1 check(!tx_ready, "busy_ready", gi, {31'h0, tx_ready}, 0);
         @(negedge clk);
         tx_valid = 1'b0;
         repeat (NB * CPB) @(negedge clk);

         // Abort during data bit 3, then a clean frame.
         send(8'($urandom), 1'b0);
         repeat (4 * CPB + 1) @(negedge clk);
         rst = 1'b1;
         #1 check_reset_vals();
         sb.delete();
         repeat (2) @(negedge clk);
         rst = 1'b0;
         send(8'h3C, 1'b0);

         for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send(b, 1'b0);
         end

         for (int n = 0; n < 1000 && (sb.size() != 0 || in_frame || expect_done); n++)
            @(negedge clk);
         check(sb.size() == 0 && !in_frame, "drain", gi, sb.size(), 0);
         check(spurious == 0, "no_spurious_done", gi, spurious, 0);
         check(par_cycles == frames_done * CPB * (PEN ? 1 : 0), "parity_cycles", gi,
               par_cycles, frames_done * CPB * (PEN ? 1 : 0));
         fin = 1;
      end
   end

   initial begin
      bit all_fin;
      all_fin = 0;
      for (int n = 0; n < 20000 && !all_fin; n++) begin
         @(negedge clk);
         all_fin = g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin;
      end
      check(all_fin, "completion", -1, {31'h0, all_fin}, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
